// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern/mask, overlapping or
// non-overlapping matching, a registered match pulse and a saturating match counter.
module seq_pattern_detector #(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] PAT_RST = 5'b10010,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);
  localparam logic [FillW-1:0] FillArm = FillW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  // The detector phase lives entirely in fill_q; this is only a named view of it.
  typedef enum logic {
    StFilling,
    StArmed
  } phase_e;

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             armed_q, armed_d;

  logic [PAT_W-1:0] nxt;
  logic             window_full;
  logic             hit;
  phase_e           phase;

  assign phase = (fill_q == FillMax) ? StArmed : StFilling;
  // After this bit is shifted in, a full PAT_W-bit window will be held.
  assign window_full = (phase == StArmed) || (fill_q == FillArm);
  assign nxt = {hist_q[PAT_W-2:0], x};

  always_comb begin
    hist_d  = hist_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    z_d     = 1'b0;
    hit     = 1'b0;

    if (cfg_load) begin
      pat_d  = cfg_pat;
      mask_d = cfg_mask;
      hist_d = '0;
      fill_d = '0;
    end else if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (x_valid) begin
      hist_d = nxt;
      hit    = ((nxt & mask_q) == (pat_q & mask_q)) && window_full;
      if (hit) begin
        z_d = 1'b1;
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (overlap) begin
          fill_d = FillMax;
        end else begin
          // Non-overlapping: the next match must be built from fresh bits only.
          fill_d = '0;
          hist_d = '0;
        end
      end else if (phase == StFilling) begin
        fill_d = fill_q + 1'b1;
      end
    end

    armed_d = (fill_d == FillMax);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      pat_q   <= PAT_RST;
      mask_q  <= '1;
      fill_q  <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      armed_q <= armed_d;
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign armed     = armed_q;

endmodule
